// File: rtl/gui_capture_pkg.sv
// Shared types and constants for the GUI frame capture block.
// The CRC helper is only referenced when GUI_CAPTURE_CRC_EN is defined.
package gui_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VSYNC,
        S_CAPTURE,
        S_DROP
    } state_t;

    localparam int PIX_W        = 4;
    localparam int PIX_PER_WORD = 8;
    localparam int WORD_W       = 32;
    localparam int ENTRY_W      = WORD_W + 2;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sof;
        logic              eol;
    } entry_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Reflected CRC-32 over one word; bytes LSB first equals bits 0..31 in order.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gui_capture_fifo.sv
// First-word-fall-through FIFO for packed capture words.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module gui_capture_fifo
    import gui_capture_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gui_frame_capture.sv
// Captures whole frames of 4-bit pixels, packs eight per word into a FIFO.
// Define GUI_CAPTURE_CRC_EN to add a per-frame CRC-32 (o_crc, o_crc_vld).
module gui_frame_capture
    import gui_capture_pkg::*;
#(
    parameter int H_ACTIVE   = 384,
    parameter int V_ACTIVE   = 256,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_vsync,
    input  logic        i_pix_vld,
    input  logic [3:0]  i_pix,
    input  logic        i_capture_en,
    input  logic        i_err_clr,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic [31:0] o_data,
    output logic        o_sof,
    output logic        o_eol,
    output logic [15:0] o_frame_cnt,
`ifdef GUI_CAPTURE_CRC_EN
    output logic [31:0] o_crc,
    output logic        o_crc_vld,
`endif
    output logic [1:0]  o_err
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int PW = WORD_W - PIX_W;

    state_t        state;
    logic          vsync_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [PW-1:0] pack_q;
    entry_t        word_q;
    logic          word_pend;
    logic          word_last;
    logic [15:0]   frame_cnt;
    logic [1:0]    err_q;

    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   vsync_fall;
    logic   done_pend;
    logic   trunc;
    logic   pix_take;
    logic   word_done;
    logic   line_end;
    logic   frame_end;
    logic   pop;
    logic   push_ok;
    logic   ovf;

    assign vsync_fall = vsync_q && !i_vsync;
    // Once the frame's last word is pending, no pixel or vsync can disturb it.
    assign done_pend  = word_pend && word_last;
    assign trunc      = (state == S_CAPTURE) && i_vsync && !done_pend;
    assign pix_take   = (state == S_CAPTURE) && !i_vsync && i_pix_vld
                        && !done_pend;
    assign word_done  = pix_take && (x_q[2:0] == 3'd7);
    assign line_end   = (x_q == XW'(H_ACTIVE - 1));
    assign frame_end  = line_end && (y_q == YW'(V_ACTIVE - 1));
    assign pop        = o_vld && i_rdy;
    assign push_ok    = word_pend && (!fifo_full || pop);
    assign ovf        = word_pend && fifo_full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            vsync_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pack_q    <= '0;
            word_q    <= '0;
            word_pend <= 1'b0;
            word_last <= 1'b0;
            frame_cnt <= '0;
            err_q     <= '0;
        end else begin
            vsync_q   <= i_vsync;
            word_pend <= word_done;
            err_q     <= (err_q & {2{~i_err_clr}}) | {trunc, ovf};

            if (word_done) begin
                word_q.data <= {i_pix, pack_q};
                word_q.sof  <= (x_q == XW'(PIX_PER_WORD - 1)) && (y_q == '0);
                word_q.eol  <= line_end;
                word_last   <= frame_end;
            end

            if (pix_take) begin
                pack_q <= {i_pix, pack_q[PW-1:PIX_W]};
                if (line_end) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end

            if (push_ok && word_last) frame_cnt <= frame_cnt + 16'd1;

            unique case (state)
                S_IDLE: begin
                    if (i_vsync) state <= S_VSYNC;
                end
                S_VSYNC: begin
                    if (vsync_fall) begin
                        if (i_capture_en) begin
                            state  <= S_CAPTURE;
                            x_q    <= '0;
                            y_q    <= '0;
                            pack_q <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (trunc)                      state <= S_VSYNC;
                    else if (ovf)                   state <= S_DROP;
                    else if (push_ok && word_last)  state <= S_IDLE;
                end
                S_DROP: begin
                    if (i_vsync) state <= S_VSYNC;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    gui_capture_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (push_ok),
        .wdata (word_q),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_vld       = !fifo_empty;
    assign o_data      = fifo_empty ? '0 : head.data;
    assign o_sof       = !fifo_empty && head.sof;
    assign o_eol       = !fifo_empty && head.eol;
    assign o_frame_cnt = frame_cnt;
    assign o_err       = err_q;

`ifdef GUI_CAPTURE_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_nxt;

    assign crc_nxt = crc32_word(crc_q, word_q.data);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            crc_q     <= CRC_INIT;
            o_crc     <= '0;
            o_crc_vld <= 1'b0;
        end else begin
            o_crc_vld <= 1'b0;
            if (state == S_VSYNC && vsync_fall && i_capture_en) begin
                crc_q <= CRC_INIT;
            end else if (push_ok) begin
                crc_q <= crc_nxt;
            end
            if (push_ok && word_last) begin
                o_crc     <= ~crc_nxt;
                o_crc_vld <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gui_frame_capture.sv
// Randomized directed-sequence bench for gui_frame_capture.
// Expected words come from a pixel-list model, not from the RTL structure.
module tb_gui_frame_capture;
    import gui_capture_pkg::*;

    localparam int H   = 16;
    localparam int V   = 4;
    localparam int D   = 4;
    localparam int WPF = H * V / 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_vsync = 1'b0;
    logic        i_pix_vld = 1'b0;
    logic [3:0]  i_pix = '0;
    logic        i_capture_en = 1'b0;
    logic        i_err_clr = 1'b0;
    logic        i_rdy = 1'b0;
    logic        o_vld;
    logic [31:0] o_data;
    logic        o_sof;
    logic        o_eol;
    logic [15:0] o_frame_cnt;
    logic [1:0]  o_err;
`ifdef GUI_CAPTURE_CRC_EN
    logic [31:0] o_crc;
    logic        o_crc_vld;
`endif

    always #5 i_clk = ~i_clk;

    gui_frame_capture #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (D)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_vsync      (i_vsync),
        .i_pix_vld    (i_pix_vld),
        .i_pix        (i_pix),
        .i_capture_en (i_capture_en),
        .i_err_clr    (i_err_clr),
        .o_vld        (o_vld),
        .i_rdy        (i_rdy),
        .o_data       (o_data),
        .o_sof        (o_sof),
        .o_eol        (o_eol),
        .o_frame_cnt  (o_frame_cnt),
`ifdef GUI_CAPTURE_CRC_EN
        .o_crc        (o_crc),
        .o_crc_vld    (o_crc_vld),
`endif
        .o_err        (o_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          fc = 0;
    logic [33:0] got[$];
    logic [33:0] exp_q[$];
    logic [3:0]  pix[$];
    logic [33:0] held;
    logic        hold_pend = 1'b0;

    // Transfers are recorded, and stalled words must hold steady.
    always @(negedge i_clk) begin
        if (hold_pend && o_vld && !i_reset) begin
            checks++;
            assert ({o_sof, o_eol, o_data} === held) else begin
                errors++;
                $error("FAIL hold observed=%h expected=%h",
                       {o_sof, o_eol, o_data}, held);
            end
        end
        hold_pend = !i_reset && o_vld && !i_rdy;
        held      = {o_sof, o_eol, o_data};
        if (!i_reset && o_vld && i_rdy) got.push_back({o_sof, o_eol, o_data});
    end

`ifdef GUI_CAPTURE_CRC_EN
    int          crc_pulses = 0;
    logic [31:0] crc_seen = '0;

    always @(negedge i_clk) begin
        if (o_crc_vld) begin
            crc_pulses++;
            crc_seen = o_crc;
        end
    end

    function automatic logic [31:0] crc_model();
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        foreach (exp_q[j]) begin
            for (int n = 0; n < 4; n++) begin
                b = exp_q[j][8*n +: 8];
                c = c ^ {24'd0, b};
                for (int t = 0; t < 8; t++)
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction
`endif

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build_exp(input int nwords);
        logic [31:0] w;
        exp_q.delete();
        for (int j = 0; j < nwords; j++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = w | (32'(pix[8*j+k]) << (4*k));
            exp_q.push_back({j == 0, ((8*j + 8) % H) == 0, w});
        end
    endfunction

    // rmode: 0 host ready, 1 random stalls, 2 host stalled.
    task automatic frame(input bit cen, input int npix, input bit ramp,
                         input int rmode);
        i_vsync = 1'b1;
        step(3);
        i_capture_en = cen;
        i_vsync = 1'b0;
        step(1);
        i_capture_en = 1'($urandom_range(0, 1));
        pix.delete();
        while (pix.size() < npix) begin
            i_pix_vld = ramp || ($urandom_range(0, 3) != 0);
            i_pix = ramp ? 4'(pix.size() % 16) : 4'($urandom_range(0, 15));
            i_rdy = (rmode == 1) ? ($urandom_range(0, 3) != 0) : (rmode == 0);
            if (i_pix_vld) pix.push_back(i_pix);
            step(1);
        end
        i_pix_vld = 1'b0;
        i_pix = 4'($urandom_range(0, 15));
        step(3);
    endtask

    task automatic drain_cmp(input string tag);
        i_rdy = 1'b1;
        for (int i = 0; i < 100 && o_vld; i++) step(1);
        step(1);
        check({tag, " drained"}, 64'(o_vld), 64'd0);
        check({tag, " count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got.size(); j++)
            check($sformatf("%s w%0d", tag, j), 64'(got[j]), 64'(exp_q[j]));
        got.delete();
    endtask

    task automatic frame_ok(input string tag);
        build_exp(WPF);
        fc++;
        check({tag, " frame_cnt"}, 64'(o_frame_cnt), 64'(16'(fc)));
`ifdef GUI_CAPTURE_CRC_EN
        check({tag, " crc"}, 64'(crc_seen), 64'(crc_model()));
`endif
        drain_cmp(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        step(2);
        i_reset = 1'b0;
        step(1);
        check("rst vld", 64'(o_vld), 64'd0);
        check("rst data", 64'(o_data), 64'd0);
        check("rst sof", 64'(o_sof), 64'd0);
        check("rst eol", 64'(o_eol), 64'd0);
        check("rst frame_cnt", 64'(o_frame_cnt), 64'd0);
        check("rst err", 64'(o_err), 64'd0);

        frame(1'b1, H * V, 1'b1, 0);
        frame_ok("ramp");

        frame(1'b1, H * V, 1'b0, 1);
        frame_ok("rand");

        frame(1'b0, H * V, 1'b0, 0);
        exp_q.delete();
        check("nocap frame_cnt", 64'(o_frame_cnt), 64'(16'(fc)));
        drain_cmp("nocap");

        frame(1'b1, H * V, 1'b0, 2);
        check("ovf err", 64'(o_err), 64'd1);
        check("ovf frame_cnt", 64'(o_frame_cnt), 64'(16'(fc)));
        build_exp(D);
        drain_cmp("ovf");
        i_err_clr = 1'b1;
        step(1);
        i_err_clr = 1'b0;
        check("err clr", 64'(o_err), 64'd0);

        frame(1'b1, H * V, 1'b0, 1);
        frame_ok("recover");
        check("recover err", 64'(o_err), 64'd0);

        frame(1'b1, 28, 1'b0, 0);
        i_vsync = 1'b1;
        i_err_clr = 1'b1;
        step(1);
        i_err_clr = 1'b0;
        check("trunc err", 64'(o_err), 64'd2);
        check("trunc frame_cnt", 64'(o_frame_cnt), 64'(16'(fc)));
        build_exp(3);
        drain_cmp("trunc");

        frame(1'b1, H * V, 1'b0, 1);
        frame_ok("post trunc");
        check("post trunc err", 64'(o_err), 64'd2);

        frame(1'b1, 28, 1'b0, 2);
        check("pre rst vld", 64'(o_vld), 64'd1);
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
        check("mid rst vld", 64'(o_vld), 64'd0);
        check("mid rst state", 64'(dut.state), 64'(S_IDLE));
        check("mid rst frame_cnt", 64'(o_frame_cnt), 64'd0);
        check("mid rst err", 64'(o_err), 64'd0);
        check("mid rst x", 64'(dut.x_q), 64'd0);
        check("mid rst y", 64'(dut.y_q), 64'd0);
        got.delete();
        fc = 0;

        frame(1'b1, H * V, 1'b0, 1);
        frame_ok("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gui_frame_capture.md
# gui_frame_capture

Downstream consumer of the Orion-PRO core video output in the GUI simulation harness. It watches the core's pixel stream, gates whole frames on a capture request, packs 4-bit colour indices eight per 32-bit word, and buffers them in a small FIFO. The GUI host drains the FIFO over a valid/ready interface with start-of-frame and end-of-line markers. It also reports overflow and truncated-frame errors.

## Interface
- H_ACTIVE, 384: active pixels per line; must be a multiple of 8
- V_ACTIVE, 256: active lines per frame
- FIFO_DEPTH, 64: output FIFO entries; power of two, at least 4
- i_clk  in  1  core clock; all logic is on the rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_vsync  in  1  core vertical sync, active-high level
- i_pix_vld  in  1  one active pixel presented this cycle
- i_pix  in  4  colour index of that pixel
- i_capture_en  in  1  capture request, sampled only at the vsync falling edge
- i_err_clr  in  1  clears the sticky error flags
- o_vld  out  1  output word available
- i_rdy  in  1  host accepts the word; a transfer happens when o_vld && i_rdy
- o_data  out  32  packed pixels; pixel k of the group sits in bits [4k+3:4k]
- o_sof  out  1  word is the first word of a frame
- o_eol  out  1  word is the last word of a line
- o_frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0
- o_err  out  2  sticky flags: bit 0 = FIFO overflow, bit 1 = truncated frame

## Operation
- States:
  - S_IDLE: wait for i_vsync = 1, then go to S_VSYNC.
  - S_VSYNC: wait for i_vsync = 0. At that edge, go to S_CAPTURE if i_capture_en = 1, otherwise S_IDLE. x/y counters and the packer are cleared on entry to S_CAPTURE.
  - S_CAPTURE: each i_pix_vld shifts i_pix into the packer.
    - On the 8th pixel, the completed word plus flags is written to the FIFO.
    - sof = 1 for the first word of the frame (x = 0, y = 0).
    - eol = 1 when the word ends at x = H_ACTIVE-1.
    - After the last word of line V_ACTIVE-1: o_frame_cnt increments and the state goes to S_IDLE.
  - S_DROP: ignore pixels; on i_vsync = 1, go to S_VSYNC.
- Pixels are ignored in every state except S_CAPTURE. Frame geometry comes only from the counters; the block has no hsync input.
- Overflow: a word is ready but the FIFO is full and no pop happens in the same cycle.
  - The word is discarded and o_err[0] is set.
  - The state goes to S_DROP, so the rest of the frame is dropped.
  - o_frame_cnt does not increment for that frame.
- Truncation: i_vsync = 1 while in S_CAPTURE.
  - o_err[1] is set and the state goes to S_VSYNC.
  - A partially packed word is discarded; words already in the FIFO are kept.
- Simultaneous push and pop when the FIFO is full: the push is accepted.
- i_err_clr clears o_err in the same cycle it is sampled. If a new error occurs in that same cycle, the set wins.
- i_capture_en changes in the middle of a frame have no effect.

## Timing
- Reset values:
  - State S_IDLE, FIFO empty.
  - o_vld = 0, o_data = 0, o_sof = 0, o_eol = 0.
  - o_frame_cnt = 0, o_err = 0.
- Asserting reset in the middle of a frame discards all FIFO contents and partial data.
- Latency: 8th pixel of a group sampled at edge N → FIFO write at edge N+1 → o_vld = 1 after edge N+1, so the word is transferable at edge N+2.
- FIFO is first-word-fall-through. o_data/o_sof/o_eol hold steady while o_vld && !i_rdy.
- Sustained rate: one pixel per cycle produces at most one word per 8 cycles. The host may stall for up to FIFO_DEPTH×8 pixel cycles without overflow.
- The vsync falling edge is detected from a registered copy. The first capturable pixel is one cycle after vsync is sampled low.
- o_frame_cnt updates at the edge that writes the final word of the frame.

## Configuration
- GUI_CAPTURE_CRC_EN defined:
  - Adds the ports o_crc (out, 32) and o_crc_vld (out, 1).
  - CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) runs over every word written to the FIFO during a frame, bytes taken LSB first.
  - At frame completion, o_crc shows the result and o_crc_vld pulses for one cycle.
  - No pulse is produced for dropped or truncated frames.
  - Reset values: o_crc = 0, o_crc_vld = 0.
- GUI_CAPTURE_CRC_EN not defined: the ports and all CRC logic are absent.

## Structure
- gui_capture_pkg holds:
  - State enum: S_IDLE, S_VSYNC, S_CAPTURE, S_DROP.
  - Constants: PIX_W = 4, PIX_PER_WORD = 8, WORD_W = 32.
  - The FIFO entry struct: data, sof, eol.
  - The CRC polynomial and init constants.
- Sub-module gui_capture_fifo: synchronous FWFT FIFO with parameter DEPTH, 34-bit entries, push/pop/full/empty.

## Test plan
- H_ACTIVE = 16, V_ACTIVE = 2, i_capture_en = 1, pixels 0..15 on each line, host always ready:
  - Expect 4 words, each 0x76543210 or 0xFEDCBA98.
  - sof only on word 0; eol on words 1 and 3.
  - o_frame_cnt = 1.
- Same frame with i_capture_en = 0 at the vsync fall: no o_vld, o_frame_cnt stays 0.
- FIFO_DEPTH = 4, i_rdy = 0, 64-pixel frame:
  - 4 words are held and o_err = 2'b01.
  - Releasing i_rdy delivers exactly 4 words.
  - The next vsync recovers and the following frame is captured.
- i_vsync raised after 1.5 lines: o_err = 2'b10, o_frame_cnt unchanged, next frame captured normally.
- Reset asserted in the middle of a frame with 3 words queued: the following cycle has o_vld = 0, state S_IDLE, all counters 0.
- With GUI_CAPTURE_CRC_EN, single word 0x00000000 frame (H_ACTIVE = 8, V_ACTIVE = 1): o_crc = 0x2144DF1C with a one-cycle o_crc_vld.
